// File: rtl/flexbex_bus_pkg.sv
// rtl/flexbex_bus_pkg.sv - shared helpers for the flexbex req/gnt/rvalid bus
package flexbex_bus_pkg;

    // Two address LSBs cleared by word alignment
    localparam int unsigned ALIGN_LSB_MASK = 3;

    // Width of an index into n entries, never less than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte-enable width for a given data width
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/flexbex_id_fifo.sv
// rtl/flexbex_id_fifo.sv - in-order FIFO of issuing port indices
module flexbex_id_fifo
    import flexbex_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy update; a push and a pop together leave count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/flexbex_obi_arbiter.sv
// rtl/flexbex_obi_arbiter.sv - round-robin N-to-1 arbiter with request lock and response routing
module flexbex_obi_arbiter
    import flexbex_bus_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUTST  = 2,
    parameter int ALIGN_ADDR = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_PORTS-1:0]                   req_i,
    output logic [NUM_PORTS-1:0]                   gnt_o,
    output logic [NUM_PORTS-1:0]                   rvalid_o,
    input  logic [NUM_PORTS-1:0]                   we_i,
    input  logic [NUM_PORTS*be_w(DATA_W)-1:0]      be_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]            addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]            wdata_i,
    output logic [NUM_PORTS*DATA_W-1:0]            rdata_o,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    output logic                                   mem_we_o,
    output logic [be_w(DATA_W)-1:0]                mem_be_o,
    output logic [ADDR_W-1:0]                      mem_addr_o,
    output logic [DATA_W-1:0]                      mem_wdata_o,
    input  logic [DATA_W-1:0]                      mem_rdata_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]         outst_o,
    output logic                                   err_o
);

    localparam int IDX_W = idx_w(NUM_PORTS);
    localparam int BE_W  = be_w(DATA_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK =
        (ALIGN_ADDR != 0) ? ~ADDR_W'(ALIGN_LSB_MASK) : {ADDR_W{1'b1}};

    logic [IDX_W-1:0] rr_ptr;
    logic             lock;
    logic [IDX_W-1:0] lock_idx;
    logic             err;
    logic [IDX_W-1:0] cand;
    logic             cand_valid;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] head;
    logic             pop;

    // Candidate: the locked port, else first requester scanning cyclically from rr_ptr
    always_comb begin
        int k;
        k          = 0;
        cand       = '0;
        cand_valid = 1'b0;
        if (lock) begin
            cand       = lock_idx;
            cand_valid = 1'b1;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                k = (int'(rr_ptr) + i) % NUM_PORTS;
                if (!cand_valid && req_i[k]) begin
                    cand       = IDX_W'(k);
                    cand_valid = 1'b1;
                end
            end
        end
    end

    assign mem_req_o   = cand_valid & ~fifo_full & ~rst_i;
    assign handshake   = mem_req_o & mem_gnt_i;
    assign pop         = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign mem_we_o    = we_i[cand];
    assign mem_be_o    = be_i[int'(cand)*BE_W +: BE_W];
    assign mem_addr_o  = addr_i[int'(cand)*ADDR_W +: ADDR_W] & ADDR_MASK;
    assign mem_wdata_o = wdata_i[int'(cand)*DATA_W +: DATA_W];
    assign rdata_o     = {NUM_PORTS{mem_rdata_i}};
    assign err_o       = err;

    // Grant goes to the candidate, response to the FIFO head
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (handshake) begin
            gnt_o[cand] = 1'b1;
        end
        if (pop) begin
            rvalid_o[head] = 1'b1;
        end
    end

    // Round-robin pointer and lock: lock holds an ungranted request steady
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (handshake) begin
            rr_ptr <= (int'(cand) == NUM_PORTS - 1) ? '0 : cand + IDX_W'(1);
            lock   <= 1'b0;
        end else if (mem_req_o) begin
            lock     <= 1'b1;
            lock_idx <= cand;
        end
    end

    // Sticky error on a response with nothing outstanding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            err <= 1'b1;
        end
    end

    flexbex_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (cand),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outst_o)
    );

endmodule

// File: tb/tb_flexbex_obi_arbiter.sv
// tb/tb_flexbex_obi_arbiter.sv - scoreboard bench for flexbex_obi_arbiter
module tb_flexbex_obi_arbiter;

    logic        clk;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [7:0]  be_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic [1:0]  gnt_o, rvalid_o;
    logic [63:0] rdata_o;
    logic        mem_req_o, mem_we_o, err_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [1:0]  outst_o;

    logic [1:0]  b_gnt, b_rvalid;
    logic [63:0] b_rdata;
    logic        b_req, b_we, b_err;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_outst;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [31:0] addr_raw;
        logic        we;
    } gnt_exp_t;

    gnt_exp_t   gnt_q[$];
    logic [1:0] rv_q[$];

    flexbex_obi_arbiter #(
        .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .ALIGN_ADDR(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .outst_o(outst_o), .err_o(err_o)
    );

    flexbex_obi_arbiter #(
        .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .ALIGN_ADDR(0)
    ) dut_noalign (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
        .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(b_rdata),
        .mem_req_o(b_req), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(b_we), .mem_be_o(b_be), .mem_addr_o(b_addr),
        .mem_wdata_o(b_wdata), .mem_rdata_i(mem_rdata_i), .outst_o(b_outst), .err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] r, input logic g, input logic rv, input logic rst);
        @(posedge clk);
        #1;
        rst_i        = rst;
        req_i        = r;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = $urandom;
    endtask

    task automatic exp_gnt(input logic [1:0] g, input logic [31:0] a, input logic [31:0] raw, input logic we);
        gnt_exp_t e;
        e.gnt = g; e.addr = a; e.addr_raw = raw; e.we = we;
        gnt_q.push_back(e);
    endtask

    // Monitor: compares every handshake and every downstream response against the queues
    always @(negedge clk) begin
        if (mem_req_o && mem_gnt_i) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_grant", {62'd0, gnt_o}, 64'd0);
            end else begin
                gnt_exp_t e;
                e = gnt_q.pop_front();
                check("gnt_o", {62'd0, gnt_o}, {62'd0, e.gnt});
                check("mem_addr_o", {32'd0, mem_addr_o}, {32'd0, e.addr});
                check("noalign_addr", {32'd0, b_addr}, {32'd0, e.addr_raw});
                check("mem_we_o", {63'd0, mem_we_o}, {63'd0, e.we});
            end
        end
        if (mem_rvalid_i) begin
            if (rv_q.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                logic [1:0] r;
                r = rv_q.pop_front();
                check("rvalid_o", {62'd0, rvalid_o}, {62'd0, r});
                check("rdata_bcast", rdata_o, {mem_rdata_i, mem_rdata_i});
            end
        end
    end

    initial begin
        rst_i = 1'b1; req_i = 2'b11; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        we_i    = 2'b10;
        be_i    = 8'hF3;
        addr_i  = {32'h0000_0304, 32'h0000_0200};
        wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};

        // Reset holds requests and grants off
        step(2'b11, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_gnt", {62'd0, gnt_o}, 64'd0);
        check("rst_outst", {62'd0, outst_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);

        // Round-robin with both ports requesting, responses one cycle behind
        step(2'b11, 1'b1, 1'b0, 1'b0);
        exp_gnt(2'b01, 32'h200, 32'h200, 1'b0);
        @(negedge clk);
        check("rr_be_port0", {60'd0, mem_be_o}, 64'h3);
        step(2'b11, 1'b1, 1'b1, 1'b0);
        exp_gnt(2'b10, 32'h304, 32'h304, 1'b1); rv_q.push_back(2'b01);
        step(2'b11, 1'b1, 1'b1, 1'b0);
        exp_gnt(2'b01, 32'h200, 32'h200, 1'b0); rv_q.push_back(2'b10);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        rv_q.push_back(2'b01);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rr_drained", {62'd0, outst_o}, 64'd0);

        // Lone port1 grant moves rr_ptr back to 0
        step(2'b10, 1'b1, 1'b0, 1'b0);
        exp_gnt(2'b10, 32'h304, 32'h304, 1'b1);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        rv_q.push_back(2'b10);

        // Lock: port1 waits on an unaligned address while port0 joins
        addr_i[63:32] = 32'h0000_0103;
        step(2'b10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lock_addr_c1", {32'd0, mem_addr_o}, 64'h100);
        check("noalign_c1", {32'd0, b_addr}, 64'h103);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lock_addr_c2", {32'd0, mem_addr_o}, 64'h100);
        check("lock_req_c2", {63'd0, mem_req_o}, 64'd1);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lock_addr_c3", {32'd0, mem_addr_o}, 64'h100);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        exp_gnt(2'b10, 32'h100, 32'h103, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        exp_gnt(2'b01, 32'h200, 32'h200, 1'b0);

        // Full FIFO: requests blocked, including the cycle that pops
        step(2'b11, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("full_req", {63'd0, mem_req_o}, 64'd0);
        check("full_outst", {62'd0, outst_o}, 64'd2);
        check("full_gnt", {62'd0, gnt_o}, 64'd0);
        step(2'b11, 1'b1, 1'b1, 1'b0);
        rv_q.push_back(2'b10);
        @(negedge clk);
        check("full_pop_req", {63'd0, mem_req_o}, 64'd0);

        // Simultaneous grant and response keep the count
        step(2'b11, 1'b1, 1'b1, 1'b0);
        exp_gnt(2'b10, 32'h100, 32'h103, 1'b1); rv_q.push_back(2'b01);
        @(negedge clk);
        check("simul_outst_before", {62'd0, outst_o}, 64'd1);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        rv_q.push_back(2'b10);
        @(negedge clk);
        check("simul_outst_after", {62'd0, outst_o}, 64'd1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_outst", {62'd0, outst_o}, 64'd0);

        // Stray response
        step(2'b00, 1'b0, 1'b1, 1'b0);
        rv_q.push_back(2'b00);
        @(negedge clk);
        check("stray_err_same", {63'd0, err_o}, 64'd0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stray_err_set", {63'd0, err_o}, 64'd1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stray_err_held", {63'd0, err_o}, 64'd1);

        // Reset with two transactions outstanding
        step(2'b11, 1'b1, 1'b0, 1'b0);
        exp_gnt(2'b01, 32'h200, 32'h200, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        exp_gnt(2'b10, 32'h100, 32'h103, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("midrst_req", {63'd0, mem_req_o}, 64'd0);
        check("midrst_gnt", {62'd0, gnt_o}, 64'd0);
        check("midrst_outst_pre", {62'd0, outst_o}, 64'd2);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_outst", {62'd0, outst_o}, 64'd0);
        check("post_rst_err", {63'd0, err_o}, 64'd0);
        check("post_rst_rrptr", {32'd0, mem_addr_o}, 64'h200);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        rv_q.push_back(2'b00);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_stray_err", {63'd0, err_o}, 64'd1);

        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
        check("rv_queue_empty", 64'(rv_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
